// File: rtl/bf_bracket_scanner_if.sv
// Handshake bundle between the BF decoder/ROM side and the bracket scanner.
// Latency: none (wires only).
// Backpressure: none; the scanner raises busy and the decoder stalls on it.
interface bf_bracket_scanner_if #(
  parameter int DEPTH_W = 8
);
  logic               start_fwd;
  logic               start_bwd;
  logic [7:0]         insn;
  logic               pc_en;
  logic               pc_down;
  logic               busy;
  logic               done;
  logic               error;
  logic [DEPTH_W-1:0] depth;

  // Decoder / ROM side: issues search requests and supplies program bytes.
  modport master (
    output start_fwd, start_bwd, insn,
    input  pc_en, pc_down, busy, done, error, depth
  );

  // Scanner side.
  modport slave (
    input  start_fwd, start_bwd, insn,
    output pc_en, pc_down, busy, done, error, depth
  );
endinterface

// File: rtl/bf_bracket_scanner.sv
// Loop-bracket search sequencer: steps the PC until the matching bracket is found.
// Latency: 3 cycles per scanned byte; done pulses 1 cycle after the matching CHECK.
// Backpressure: busy stalls the decoder; start is only accepted in IDLE. Optional BF_SCAN_LIMIT_EN adds a step-limit abort.
module bf_bracket_scanner #(
  parameter int DEPTH_W    = 8
`ifdef BF_SCAN_LIMIT_EN
  ,
  parameter int LIMIT_W    = 16,
  parameter int SCAN_LIMIT = 65535
`endif
) (
  input logic                clk_i,
  input logic                rst_n_i,
  bf_bracket_scanner_if.slave scan_if
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_STEP  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_FAIL  = 3'd5;

  localparam logic [7:0] CH_OPEN  = 8'h5B;
  localparam logic [7:0] CH_CLOSE = 8'h5D;

  logic [2:0]         state_q, state_d;
  logic               dir_q, dir_d;      // 1 = searching backward (PC decrements)
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               error_q, error_d;
  logic               same_br, opp_br;

`ifdef BF_SCAN_LIMIT_EN
  logic [LIMIT_W-1:0] steps_q, steps_d;
`endif

  // A bracket equal to the origin opens another level; the opposite one closes one.
  always_comb begin
    same_br = dir_q ? (scan_if.insn == CH_CLOSE) : (scan_if.insn == CH_OPEN);
    opp_br  = dir_q ? (scan_if.insn == CH_OPEN)  : (scan_if.insn == CH_CLOSE);
  end

  // Next-state logic for the search sequencer.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    depth_d = depth_q;
    error_d = error_q;
`ifdef BF_SCAN_LIMIT_EN
    steps_d = steps_q;
`endif
    case (state_q)
      S_IDLE: begin
        // After an abort the block stays parked until reset.
        if (!error_q && (scan_if.start_fwd || scan_if.start_bwd)) begin
          dir_d   = !scan_if.start_fwd;
          depth_d = DEPTH_W'(1);
          state_d = S_STEP;
`ifdef BF_SCAN_LIMIT_EN
          steps_d = '0;
`endif
        end
      end
      S_STEP: begin
        state_d = S_WAIT;
`ifdef BF_SCAN_LIMIT_EN
        steps_d = steps_q + LIMIT_W'(1);
`endif
      end
      S_WAIT: state_d = S_CHECK;
      S_CHECK: begin
        state_d = S_STEP;
        if (same_br) begin
          if (&depth_q) state_d = S_FAIL;
          else          depth_d = depth_q + DEPTH_W'(1);
        end else if (opp_br) begin
          depth_d = depth_q - DEPTH_W'(1);
          if (depth_q == DEPTH_W'(1)) state_d = S_DONE;
        end
`ifdef BF_SCAN_LIMIT_EN
        // A match found on the last allowed step still wins over the abort.
        if (state_d == S_STEP && steps_q >= LIMIT_W'(SCAN_LIMIT)) state_d = S_FAIL;
`endif
      end
      S_DONE: begin
        depth_d = '0;
        state_d = S_IDLE;
      end
      S_FAIL: begin
        error_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset mid-search drops straight back to IDLE.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      dir_q   <= 1'b0;
      depth_q <= '0;
      error_q <= 1'b0;
`ifdef BF_SCAN_LIMIT_EN
      steps_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      depth_q <= depth_d;
      error_q <= error_d;
`ifdef BF_SCAN_LIMIT_EN
      steps_q <= steps_d;
`endif
    end
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    scan_if.pc_en   = (state_q == S_STEP);
    scan_if.busy    = (state_q == S_STEP) || (state_q == S_WAIT) ||
                      (state_q == S_CHECK) || (state_q == S_DONE);
    scan_if.pc_down = scan_if.busy && dir_q;
    scan_if.done    = (state_q == S_DONE);
    scan_if.error   = error_q || (state_q == S_FAIL);
    scan_if.depth   = depth_q;
  end

endmodule

// File: tb/tb_bf_bracket_scanner.sv
// Bench for bf_bracket_scanner: two instances (wide depth, and 2-bit depth for overflow / limit abort).
// A shared ROM and per-instance PC counters model the surrounding core.
// Expected per-cycle outputs come from a plain scan model of the bracket-matching rules.
module tb_bf_bracket_scanner;

  localparam logic [7:0] OPEN  = 8'h5B;
  localparam logic [7:0] CLOSE = 8'h5D;
  localparam logic [7:0] PLUS  = 8'h2B;
  localparam int MAXS = 300;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bf_bracket_scanner_if #(.DEPTH_W(8)) if0 ();
  bf_bracket_scanner_if #(.DEPTH_W(2)) if1 ();

  bf_bracket_scanner #(
    .DEPTH_W(8)
`ifdef BF_SCAN_LIMIT_EN
    , .LIMIT_W(16), .SCAN_LIMIT(65535)
`endif
  ) u_dut0 (.clk_i(clk), .rst_n_i(rst_n), .scan_if(if0));

  bf_bracket_scanner #(
    .DEPTH_W(2)
`ifdef BF_SCAN_LIMIT_EN
    , .LIMIT_W(4), .SCAN_LIMIT(5)
`endif
  ) u_dut1 (.clk_i(clk), .rst_n_i(rst_n), .scan_if(if1));

  // ---------------- environment: ROM + PC counters ----------------
  logic [7:0] rom [256];
  logic [7:0] pc0 = 8'd0, pc1 = 8'd0, ldv = 8'd0;
  logic       ld0 = 1'b0, ld1 = 1'b0;

  always @(posedge clk) begin
    if (ld0) pc0 <= ldv;
    else if (if0.pc_en) pc0 <= if0.pc_down ? pc0 - 8'd1 : pc0 + 8'd1;
    if (ld1) pc1 <= ldv;
    else if (if1.pc_en) pc1 <= if1.pc_down ? pc1 - 8'd1 : pc1 + 8'd1;
    if0.insn <= rom[pc0];
    if1.insn <= rom[pc1];
  end

  // ---------------- checking ----------------
  typedef struct {
    bit pc_en, pc_down, busy, done, error, chk_depth;
    int depth;
  } exp_t;

  exp_t ex[2];
  bit   err_st[2];
  bit   cmp_en = 1'b0;
  int   pe_cnt[2];
  int   n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, expv);
    end
  endtask

  task automatic cmp_one(input int s, input logic pe, input logic pd, input logic bz,
                         input logic dn, input logic er, input logic [7:0] dp);
    string p;
    p = (s == 0) ? "dut0" : "dut1";
    chk({p, ".pc_en"},   {31'd0, pe}, {31'd0, ex[s].pc_en});
    chk({p, ".pc_down"}, {31'd0, pd}, {31'd0, ex[s].pc_down});
    chk({p, ".busy"},    {31'd0, bz}, {31'd0, ex[s].busy});
    chk({p, ".done"},    {31'd0, dn}, {31'd0, ex[s].done});
    chk({p, ".error"},   {31'd0, er}, {31'd0, ex[s].error});
    if (ex[s].chk_depth) chk({p, ".depth"}, {24'd0, dp}, ex[s].depth);
  endtask

  // Single compare process: both instances against the model, every cycle.
  always @(negedge clk) begin
    if (cmp_en) begin
      cmp_one(0, if0.pc_en, if0.pc_down, if0.busy, if0.done, if0.error, if0.depth);
      cmp_one(1, if1.pc_en, if1.pc_down, if1.busy, if1.done, if1.error, {6'd0, if1.depth});
      if (if0.pc_en) pe_cnt[0]++;
      if (if1.pc_en) pe_cnt[1]++;
    end
  end

  // ---------------- behavioural scan model ----------------
  int m_steps, m_match;
  bit m_fail, m_end;
  int m_dep [MAXS+1];
  int lim [2];

  function automatic void model_scan(input int s, input bit down, input int start);
    int p, d, dmax;
    logic [7:0] b;
    p = start; d = 1; dmax = (s == 0) ? 255 : 3;
    m_steps = 0; m_fail = 0; m_end = 0; m_match = -1;
    while (!m_end && m_steps < MAXS) begin
      m_dep[m_steps] = d;
      p = (p + (down ? 255 : 1)) % 256;
      m_steps++;
      b = rom[p];
      if (b == (down ? CLOSE : OPEN)) begin
        if (d == dmax) begin m_fail = 1; m_end = 1; end
        else d++;
      end else if (b == (down ? OPEN : CLOSE)) begin
        d--;
        if (d == 0) begin m_end = 1; m_match = p; end
      end
      if (!m_end && lim[s] != 0 && m_steps >= lim[s]) begin m_fail = 1; m_end = 1; end
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic set_start(input int s, input bit f, input bit b);
    if (s == 0) begin if0.start_fwd = f; if0.start_bwd = b; end
    else        begin if1.start_fwd = f; if1.start_bwd = b; end
  endtask

  task automatic idle_exp(input int s);
    ex[s] = '{pc_en: 0, pc_down: 0, busy: 0, done: 0, error: err_st[s],
              chk_depth: !err_st[s], depth: 0};
  endtask

  task automatic clear_rom(input logic [7:0] fill);
    for (int i = 0; i < 256; i++) rom[i] = fill;
  endtask

  task automatic load_prog(input string s);
    clear_rom(8'h00);
    for (int i = 0; i < s.len(); i++) rom[i] = s[i];
  endtask

  // One search on instance s; the model is evaluated first, then replayed cycle by cycle.
  task automatic run(input int s, input bit sf, input bit sb, input int start, input bit noisy);
    bit down;
    int total;
    down = sb && !sf;
    @(posedge clk); #1;
    ldv = 8'(start);
    if (s == 0) ld0 = 1'b1; else ld1 = 1'b1;
    idle_exp(0); idle_exp(1);
    @(posedge clk); #1;
    ld0 = 1'b0; ld1 = 1'b0;
    model_scan(s, down, start);
    set_start(s, sf, sb);
    if (err_st[s]) begin
      for (int c = 0; c < 5; c++) begin
        @(posedge clk); #1;
        set_start(s, 1'b0, 1'b0);
      end
      return;
    end
    total = 3 * m_steps + 1;
    for (int c = 1; c <= total; c++) begin
      @(posedge clk); #1;
      if (noisy) set_start(s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else       set_start(s, 1'b0, 1'b0);
      if (c < total) begin
        ex[s] = '{pc_en: ((c - 1) % 3 == 0), pc_down: down, busy: 1, done: 0, error: 0,
                  chk_depth: 1, depth: m_dep[(c - 1) / 3]};
      end else if (!m_fail) begin
        ex[s] = '{pc_en: 0, pc_down: down, busy: 1, done: 1, error: 0, chk_depth: 1, depth: 0};
        chk("pc_at_done", {24'd0, (s == 0) ? pc0 : pc1}, m_match);
      end else begin
        ex[s] = '{pc_en: 0, pc_down: 0, busy: 0, done: 0, error: 1, chk_depth: 0, depth: 0};
        err_st[s] = 1'b1;
      end
    end
    @(posedge clk); #1;
    set_start(s, 1'b0, 1'b0);
    idle_exp(s);
    @(posedge clk); #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int pe_base, tries, st;
    bit sf, sb;
    logic [7:0] r;
    set_start(0, 1'b0, 1'b0);
    set_start(1, 1'b0, 1'b0);
    err_st[0] = 0; err_st[1] = 0;
    pe_cnt[0] = 0; pe_cnt[1] = 0;
`ifdef BF_SCAN_LIMIT_EN
    lim[0] = 65535; lim[1] = 5;
`else
    lim[0] = 0; lim[1] = 0;
`endif
    clear_rom(8'h00);
    idle_exp(0); idle_exp(1);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy",  {31'd0, if0.busy},  0);
    chk("rst.pc_en", {31'd0, if0.pc_en}, 0);
    chk("rst.done",  {31'd0, if0.done},  0);
    chk("rst.error", {31'd0, if1.error}, 0);
    chk("rst.depth", {24'd0, if0.depth}, 0);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    // "[]" forward: one step, match at PC 1
    load_prog("[]");
    run(0, 1, 0, 0, 0);
    chk("t1.steps", m_steps, 1);
    chk("t1.match", m_match, 1);

    // "[+[-]>]" forward: six steps, match at PC 6
    load_prog("[+[-]>]");
    pe_base = pe_cnt[0];
    run(0, 1, 0, 0, 0);
    chk("t2.steps", m_steps, 6);
    chk("t2.match", m_match, 6);
    chk("t2.pc_en_pulses", pe_cnt[0] - pe_base, 6);

    // "[[-]]" backward from PC 4: match at PC 0
    load_prog("[[-]]");
    run(0, 0, 1, 4, 0);
    chk("t3.steps", m_steps, 4);
    chk("t3.match", m_match, 0);

    // Both starts high: forward wins; stray starts during the search
    load_prog("[+[-]>]");
    run(0, 1, 1, 0, 1);
    load_prog("[[-]]");
    run(0, 1, 1, 0, 1);

    // Randomised programs, starting points and directions
    for (int it = 0; it < 40; it++) begin
      tries = 0;
      do begin
        for (int i = 0; i < 256; i++) begin
          case ($urandom_range(0, 9))
            0, 1, 2:    r = OPEN;
            3, 4, 5:    r = CLOSE;
            6, 7, 8:    r = PLUS;
            default:    r = 8'($urandom_range(0, 255));
          endcase
          rom[i] = r;
        end
        st = $urandom_range(0, 255);
        case ($urandom_range(0, 2))
          0:       begin sf = 1; sb = 0; end
          1:       begin sf = 0; sb = 1; end
          default: begin sf = 1; sb = 1; end
        endcase
        model_scan(0, sb && !sf, st);
        tries++;
      end while ((m_fail || !m_end || m_steps > 60) && tries < 50);
      if (m_end && !m_fail) run(0, sf, sb, st, 1'($urandom_range(0, 1)));
    end

    // Depth overflow on the 2-bit instance: abort on the 4th '['
    load_prog("[[[[");
    run(1, 1, 0, 0, 0);
    chk("t5.fail", {31'd0, m_fail}, 1);
    chk("t5.steps", m_steps, 3);
    chk("t5.error_sticky", {31'd0, if1.error}, 1);
    chk("t5.busy", {31'd0, if1.busy}, 0);
    // Sticky error: a further start is ignored
    load_prog("[]");
    run(1, 1, 0, 0, 0);

    // Reset mid-scan on an unmatched bracket
    clear_rom(PLUS);
    rom[0] = OPEN;
    cmp_en = 1'b0;
    @(posedge clk); #1;
    ldv = 8'd0; ld0 = 1'b1;
    @(posedge clk); #1;
    ld0 = 1'b0;
    set_start(0, 1'b1, 1'b0);
    @(posedge clk); #1;
    set_start(0, 1'b0, 1'b0);
    chk("t6.pc_en_c1", {31'd0, if0.pc_en}, 1);
    repeat (6) @(posedge clk);
    #1;
    chk("t6.busy_pre", {31'd0, if0.busy}, 1);
    chk("t6.pc_en_pre", {31'd0, if0.pc_en}, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6.busy",  {31'd0, if0.busy},  0);
    chk("t6.pc_en", {31'd0, if0.pc_en}, 0);
    chk("t6.done",  {31'd0, if0.done},  0);
    chk("t6.depth", {24'd0, if0.depth}, 0);
    chk("t6.error1_cleared", {31'd0, if1.error}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    err_st[0] = 0; err_st[1] = 0;
    idle_exp(0); idle_exp(1);
    cmp_en = 1'b1;
    @(posedge clk); #1;

`ifdef BF_SCAN_LIMIT_EN
    // Unmatched bracket with a 5-step limit: abort, no done
    clear_rom(PLUS);
    rom[0] = OPEN;
    pe_base = pe_cnt[1];
    run(1, 1, 0, 0, 0);
    chk("t6.limit_fail", {31'd0, m_fail}, 1);
    chk("t6.limit_steps", m_steps, 5);
    chk("t6.limit_pulses", pe_cnt[1] - pe_base, 5);
    chk("t6.limit_error", {31'd0, if1.error}, 1);
`endif

    // A final ordinary search after reset
    load_prog("[+[-]>]");
    run(0, 1, 0, 0, 0);

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
